// File: rtl/inst_fetch_unit_if.sv
// Instruction-fetch bundle: the instruction-memory request/grant/response
// handshake, the branch/jump redirect, and the IF/ID register side.
// The master modport is the fetch unit. The slave modport is its environment
// (memory, ID stage and branch resolution).
interface inst_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instruction;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc_plus4, if_instruction, fetch_fault,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc_plus4, if_instruction, fetch_fault,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage. Issues word addresses to instruction memory and
// buffers the returned words in an in-order queue. The queue head goes to
// IF/ID. A redirect flushes the queue. Responses still in flight are then
// counted as "drop" and discarded when they arrive.
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to flag misaligned redirect
// targets with a sticky fetch_fault that stops fetching until rst. Without
// it, the low two bits of redirect_pc are forced to zero and fetch_fault
// is tied low.
//
// BUF_DEPTH may be 2 or 4. It sizes the queue and also caps the number of
// requests in flight.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input logic                clk,
    input logic                rst,
    inst_fetch_unit_if.master  bus
);

    localparam int               PTR_W   = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int               CNT_W   = 4;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    logic [31:0]      pc_fetch_q, pc_fetch_d;
    logic [31:0]      pc_head_q, pc_head_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] live_q, live_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      buf_q [BUF_DEPTH];
    logic [31:0]      buf_d [BUF_DEPTH];

    logic [31:0]      redirect_tgt;
    logic             fault_active;
    logic             credit_ok;
    logic             req;
    logic             accept;
    logic             pop;
    logic             rsp_drop;
    logic             rsp_push;
    logic [CNT_W-1:0] owed;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign redirect_tgt = bus.redirect_pc;
    assign fault_active = fault_q;

    // Sticky fault: set by a redirect to a misaligned target, cleared only by rst
    always_comb begin
        fault_d = fault_q;
        if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
            fault_d = 1'b1;
        end
    end

    // Fault flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;
    assign fault_active = 1'b0;
`endif

    // Credits count what is buffered and what is still owed, so every accepted
    // request is guaranteed a queue slot and the owed-response counters cannot overflow.
    assign credit_ok = ((count_q + live_q) < DEPTH_C) && ((live_q + drop_q) < DEPTH_C);
    assign req       = !rst && !bus.redirect_valid && credit_ok && !fault_active;
    assign accept    = req && bus.imem_gnt;
    assign pop       = (count_q != '0) && bus.id_ready && !bus.redirect_valid;
    assign rsp_drop  = bus.imem_rvalid && (drop_q != '0);
    assign rsp_push  = bus.imem_rvalid && (drop_q == '0) && (live_q != '0);
    assign owed      = drop_q + live_q;

    assign bus.imem_req       = req;
    assign bus.imem_addr      = pc_fetch_q;
    assign bus.if_valid       = (count_q != '0);
    assign bus.if_pc_plus4    = pc_head_q + 32'd4;
    assign bus.if_instruction = (count_q != '0) ? buf_q[rd_ptr_q] : 32'h0000_0000;
    assign bus.fetch_fault    = fault_active;

    // Next-state: a redirect overrides everything, otherwise accept/push/pop/drop update independently
    always_comb begin
        pc_fetch_d = pc_fetch_q;
        pc_head_d  = pc_head_q;
        count_d    = count_q;
        live_d     = live_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_d[i] = buf_q[i];
        end

        if (bus.redirect_valid) begin
            pc_fetch_d = redirect_tgt;
            pc_head_d  = redirect_tgt;
            count_d    = '0;
            live_d     = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = owed - ((bus.imem_rvalid && (owed != '0)) ? CNT_W'(1) : CNT_W'(0));
        end else begin
            if (accept) begin
                pc_fetch_d = pc_fetch_q + 32'd4;
            end
            if (rsp_drop) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (rsp_push) begin
                buf_d[wr_ptr_q] = bus.imem_rdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                pc_head_d = pc_head_q + 32'd4;
            end
            count_d = count_q + CNT_W'(rsp_push) - CNT_W'(pop);
            live_d  = live_q + CNT_W'(accept) - CNT_W'(rsp_push);
        end
    end

    // Control and address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_fetch_q <= RESET_PC;
            pc_head_q  <= RESET_PC;
            count_q    <= '0;
            live_q     <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_fetch_q <= pc_fetch_d;
            pc_head_q  <= pc_head_d;
            count_q    <= count_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Instruction storage has no reset; the head is masked to NOP whenever the queue is empty
    always_ff @(posedge clk) begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_q[i] <= buf_d[i];
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit (BUF_DEPTH=2, RESET_PC=0).
// A small in-order memory model answers accepted requests after a fixed
// latency with a word derived from the address. The checks are written out
// in each test task.
module tb_inst_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    inst_fetch_unit_if bus();

    inst_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;

    logic [31:0] pend_a [$];
    int          pend_t [$];
    logic [31:0] issued [$];
    logic [31:0] del_pc4 [$];
    logic [31:0] del_ins [$];

    logic        s_req, s_valid, s_fault;
    logic [31:0] s_addr, s_pc4, s_ins;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // One clock cycle: drive inputs after the falling edge, let the
    // combinational outputs settle, then sample them and log what happened.
    task automatic applyStimulus(input logic r, input logic g, input logic rdy,
                                 input logic rv, input logic [31:0] rpc);
        logic [31:0] tmp_a;
        int          tmp_t;
        @(negedge clk);
        cyc++;
        rst                = r;
        bus.imem_gnt       = g;
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        if (r) begin
            pend_a.delete();
            pend_t.delete();
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'h1234_5678;
        end else if (pend_a.size() > 0 && cyc >= pend_t[0] + lat) begin
            tmp_a = pend_a.pop_front();
            tmp_t = pend_t.pop_front();
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(tmp_a);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'hDEAD_0000 ^ 32'(cyc);
        end
        #1;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.if_valid;
        s_pc4   = bus.if_pc_plus4;
        s_ins   = bus.if_instruction;
        s_fault = bus.fetch_fault;
        if (s_req === 1'b1 && g) begin
            pend_a.push_back(s_addr);
            pend_t.push_back(cyc);
            issued.push_back(s_addr);
        end
        if (s_valid === 1'b1 && rdy && !rv) begin
            del_pc4.push_back(s_pc4);
            del_ins.push_back(s_ins);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        issued.delete();
        del_pc4.delete();
        del_ins.delete();
    endtask

    task automatic run(input int n, input logic g, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, g, rdy, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        lat = 1;
        do_reset();
        checks++; if (s_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %0b expected 0", s_req); end
        checks++; if (s_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b expected 0", s_valid); end
        checks++; if (s_ins !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr: got %h expected 00000000", s_ins); end
        checks++; if (s_pc4 !== 32'h4) begin failures++; $display("[TB] FAIL reset_pc4: got %h expected 00000004", s_pc4); end
        checks++; if (s_fault !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault: got %0b expected 0", s_fault); end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin failures++; $display("[TB] FAIL first_req: got req=%0b addr=%h expected req=1 addr=00000000", s_req, s_addr); end
        checks++; if (s_valid !== 1'b0) begin failures++; $display("[TB] FAIL rvalid_in_reset_ignored: got valid=%0b expected 0", s_valid); end
    endtask

    task automatic test_basic_fetch();
        lat = 1;
        do_reset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (s_valid !== 1'b0) begin failures++; $display("[TB] FAIL latency_c1: got valid=%0b expected 0", s_valid); end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (s_valid !== 1'b1 || s_pc4 !== 32'h4 || s_ins !== mem_word(32'h0)) begin failures++; $display("[TB] FAIL latency_c2: got valid=%0b pc4=%h ins=%h expected 1 00000004 %h", s_valid, s_pc4, s_ins, mem_word(32'h0)); end
        run(20, 1'b1, 1'b1);
        checks++; if (issued.size() < 10 || del_pc4.size() < 10) begin failures++; $display("[TB] FAIL basic_progress: got issued=%0d delivered=%0d expected >=10 each", issued.size(), del_pc4.size()); end
        for (int i = 0; i < issued.size(); i++) begin
            checks++; if (issued[i] !== 32'(4 * i)) begin failures++; $display("[TB] FAIL basic_issue[%0d]: got %h expected %h", i, issued[i], 32'(4 * i)); end
        end
        for (int i = 0; i < del_pc4.size(); i++) begin
            checks++; if (del_pc4[i] !== 32'(4 * i + 4) || del_ins[i] !== mem_word(32'(4 * i))) begin failures++; $display("[TB] FAIL basic_deliver[%0d]: got pc4=%h ins=%h expected %h %h", i, del_pc4[i], del_ins[i], 32'(4 * i + 4), mem_word(32'(4 * i))); end
        end
    endtask

    task automatic test_stall();
        lat = 1;
        do_reset();
        run(6, 1'b1, 1'b0);
        checks++; if (issued.size() != 2) begin failures++; $display("[TB] FAIL stall_accepts: got %0d expected 2", issued.size()); end
        checks++; if (s_req !== 1'b0) begin failures++; $display("[TB] FAIL stall_req: got %0b expected 0", s_req); end
        checks++; if (s_valid !== 1'b1 || s_pc4 !== 32'h4 || s_ins !== mem_word(32'h0)) begin failures++; $display("[TB] FAIL stall_head: got valid=%0b pc4=%h ins=%h expected 1 00000004 %h", s_valid, s_pc4, s_ins, mem_word(32'h0)); end
        run(20, 1'b1, 1'b1);
        checks++; if (del_pc4.size() < 8) begin failures++; $display("[TB] FAIL stall_resume: got delivered=%0d expected >=8", del_pc4.size()); end
        for (int i = 0; i < del_pc4.size(); i++) begin
            checks++; if (del_pc4[i] !== 32'(4 * i + 4) || del_ins[i] !== mem_word(32'(4 * i))) begin failures++; $display("[TB] FAIL stall_deliver[%0d]: got pc4=%h ins=%h expected %h %h", i, del_pc4[i], del_ins[i], 32'(4 * i + 4), mem_word(32'(4 * i))); end
        end
    endtask

    task automatic test_redirect_latency();
        int n_iss;
        int n_del;
        lat = 3;
        do_reset();
        run(2, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
        checks++; if (s_req !== 1'b0) begin failures++; $display("[TB] FAIL redir_req_comb: got %0b expected 0", s_req); end
        n_iss = issued.size();
        n_del = del_pc4.size();
        checks++; if (n_iss != 2 || n_del != 0) begin failures++; $display("[TB] FAIL redir_pre_state: got issued=%0d delivered=%0d expected 2 0", n_iss, n_del); end
        run(20, 1'b1, 1'b1);
        checks++; if (del_pc4.size() < 3) begin failures++; $display("[TB] FAIL redir_progress: got delivered=%0d expected >=3", del_pc4.size()); end
        for (int i = n_iss; i < issued.size(); i++) begin
            checks++; if (issued[i] !== 32'h100 + 32'(4 * (i - n_iss))) begin failures++; $display("[TB] FAIL redir_issue[%0d]: got %h expected %h", i, issued[i], 32'h100 + 32'(4 * (i - n_iss))); end
        end
        for (int i = 0; i < del_pc4.size(); i++) begin
            checks++; if (del_pc4[i] !== 32'h104 + 32'(4 * i) || del_ins[i] !== mem_word(32'h100 + 32'(4 * i))) begin failures++; $display("[TB] FAIL redir_deliver[%0d]: got pc4=%h ins=%h expected %h %h", i, del_pc4[i], del_ins[i], 32'h104 + 32'(4 * i), mem_word(32'h100 + 32'(4 * i))); end
        end
    endtask

    task automatic test_redirect_rvalid();
        lat = 1;
        do_reset();
        run(2, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        checks++; if (s_req !== 1'b0) begin failures++; $display("[TB] FAIL rr_req: got %0b expected 0", s_req); end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (s_valid !== 1'b0) begin failures++; $display("[TB] FAIL rr_flush: got valid=%0b expected 0", s_valid); end
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin failures++; $display("[TB] FAIL rr_refetch: got req=%0b addr=%h expected 1 00000200", s_req, s_addr); end
        checks++; if (s_pc4 !== 32'h204) begin failures++; $display("[TB] FAIL rr_head_pc4: got %h expected 00000204", s_pc4); end
        run(10, 1'b1, 1'b1);
        checks++; if (del_pc4.size() < 2) begin failures++; $display("[TB] FAIL rr_progress: got delivered=%0d expected >=2", del_pc4.size()); end
        for (int i = 0; i < del_pc4.size(); i++) begin
            checks++; if (del_pc4[i] !== 32'h204 + 32'(4 * i) || del_ins[i] !== mem_word(32'h200 + 32'(4 * i))) begin failures++; $display("[TB] FAIL rr_deliver[%0d]: got pc4=%h ins=%h expected %h %h", i, del_pc4[i], del_ins[i], 32'h204 + 32'(4 * i), mem_word(32'h200 + 32'(4 * i))); end
        end
    endtask

    task automatic test_gnt_toggle();
        lat = 1;
        do_reset();
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, (i % 2 == 0), 1'b1, 1'b0, 32'h0);
        checks++; if (issued.size() < 8 || del_pc4.size() < 6) begin failures++; $display("[TB] FAIL gnt_progress: got issued=%0d delivered=%0d expected >=8 >=6", issued.size(), del_pc4.size()); end
        for (int i = 0; i < issued.size(); i++) begin
            checks++; if (issued[i] !== 32'(4 * i)) begin failures++; $display("[TB] FAIL gnt_issue[%0d]: got %h expected %h", i, issued[i], 32'(4 * i)); end
        end
        for (int i = 0; i < del_pc4.size(); i++) begin
            checks++; if (del_pc4[i] !== 32'(4 * i + 4) || del_ins[i] !== mem_word(32'(4 * i))) begin failures++; $display("[TB] FAIL gnt_deliver[%0d]: got pc4=%h ins=%h expected %h %h", i, del_pc4[i], del_ins[i], 32'(4 * i + 4), mem_word(32'(4 * i))); end
        end
    endtask

    task automatic test_wrap();
        int n_iss;
        lat = 1;
        do_reset();
        run(1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        n_iss = issued.size();
        run(15, 1'b1, 1'b1);
        checks++; if (issued.size() < n_iss + 4 || del_pc4.size() < 4) begin failures++; $display("[TB] FAIL wrap_progress: got issued=%0d delivered=%0d", issued.size(), del_pc4.size()); end
        for (int i = n_iss; i < issued.size(); i++) begin
            checks++; if (issued[i] !== 32'hFFFF_FFF8 + 32'(4 * (i - n_iss))) begin failures++; $display("[TB] FAIL wrap_issue[%0d]: got %h expected %h", i, issued[i], 32'hFFFF_FFF8 + 32'(4 * (i - n_iss))); end
        end
        for (int i = 0; i < del_pc4.size(); i++) begin
            checks++; if (del_pc4[i] !== 32'hFFFF_FFFC + 32'(4 * i) || del_ins[i] !== mem_word(32'hFFFF_FFF8 + 32'(4 * i))) begin failures++; $display("[TB] FAIL wrap_deliver[%0d]: got pc4=%h ins=%h expected %h %h", i, del_pc4[i], del_ins[i], 32'hFFFF_FFFC + 32'(4 * i), mem_word(32'hFFFF_FFF8 + 32'(4 * i))); end
        end
    endtask

    task automatic test_misaligned_redirect();
        lat = 1;
        do_reset();
        run(2, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h102);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (s_fault !== 1'b1) begin failures++; $display("[TB] FAIL fault_set: got %0b expected 1", s_fault); end
        checks++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin failures++; $display("[TB] FAIL fault_quiet: got req=%0b valid=%0b expected 0 0", s_req, s_valid); end
        run(6, 1'b1, 1'b1);
        checks++; if (issued.size() != 2 || del_pc4.size() != 0) begin failures++; $display("[TB] FAIL fault_hold: got issued=%0d delivered=%0d expected 2 0", issued.size(), del_pc4.size()); end
        checks++; if (s_fault !== 1'b1 || s_valid !== 1'b0) begin failures++; $display("[TB] FAIL fault_sticky: got fault=%0b valid=%0b expected 1 0", s_fault, s_valid); end
        do_reset();
        checks++; if (s_fault !== 1'b0) begin failures++; $display("[TB] FAIL fault_clear: got %0b expected 0", s_fault); end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin failures++; $display("[TB] FAIL fault_restart: got req=%0b addr=%h expected 1 00000000", s_req, s_addr); end
`else
        checks++; if (s_fault !== 1'b0) begin failures++; $display("[TB] FAIL nofault_flag: got %0b expected 0", s_fault); end
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin failures++; $display("[TB] FAIL nofault_addr: got req=%0b addr=%h expected 1 00000100", s_req, s_addr); end
        run(6, 1'b1, 1'b1);
        checks++; if (del_pc4.size() < 1) begin failures++; $display("[TB] FAIL nofault_progress: got delivered=%0d expected >=1", del_pc4.size()); end
        for (int i = 0; i < del_pc4.size(); i++) begin
            checks++; if (del_pc4[i] !== 32'h104 + 32'(4 * i) || del_ins[i] !== mem_word(32'h100 + 32'(4 * i))) begin failures++; $display("[TB] FAIL nofault_deliver[%0d]: got pc4=%h ins=%h expected %h %h", i, del_pc4[i], del_ins[i], 32'h104 + 32'(4 * i), mem_word(32'h100 + 32'(4 * i))); end
        end
`endif
    endtask

    // Test sequence
    initial begin
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_latency();
        test_redirect_rvalid();
        test_gnt_toggle();
        test_wrap();
        test_misaligned_redirect();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
